// File: rtl/fifo_frame_bridge_pkg.sv
// Shared types and constants for the FIFO-to-CPU frame bridge.
package fifo_frame_bridge_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned OVR_W = 16;

  // Address width of a {channel, sample index} buffer address.
  function automatic int unsigned frame_addr_w(input int unsigned channels,
                                               input int unsigned frame_len);
    return $clog2(channels) + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/fifo_frame_bridge_if.sv
// Read-side handshake of a non-show-ahead FIFO feeding the frame bridge.
interface fifo_frame_bridge_if #(
  parameter int unsigned DATA_W = 32
);

  logic [DATA_W-1:0] fifo_q;
  logic              fifo_rdempty;
  logic              fifo_rdfull;
  logic              fifo_rdreq;

  // master: the reader (bridge); slave: the FIFO itself
  modport master (
    input  fifo_q,
    input  fifo_rdempty,
    input  fifo_rdfull,
    output fifo_rdreq
  );

  modport slave (
    output fifo_q,
    output fifo_rdempty,
    output fifo_rdfull,
    input  fifo_rdreq
  );

endinterface

// File: rtl/ffb_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module ffb_frame_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_frame_bridge.sv
// Drains one interleaved frame from a FIFO into a CPU-readable buffer.
// Optional overrun statistic: define FIFO_FRAME_BRIDGE_OVERRUN_CNT_EN.
module fifo_frame_bridge
  import fifo_frame_bridge_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned CHANNELS  = 2,
  parameter  int unsigned FRAME_LEN = 16,
  localparam int unsigned AW        = frame_addr_w(CHANNELS, FRAME_LEN)
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  fifo_frame_bridge_if.master fifo,
  output logic                frame_ready,
  input  logic [AW-1:0]       cpu_rd_addr,
  output logic [DATA_W-1:0]   cpu_rd_data,
  input  logic                cpu_frame_ack,
  input  logic [DATA_W-1:0]   cpu_back_data,
  input  logic                cpu_back_wr,
  output logic [DATA_W-1:0]   data_back,
  output logic                data_back_stb,
  output logic [OVR_W-1:0]    overrun_cnt
);

  localparam int unsigned DEPTH = CHANNELS * FRAME_LEN;
  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   ch;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  issued;
  logic              cap_vld;
  logic              ch_last;
  logic              last_cap;
  logic              rd_ok;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] ram_q;

  assign ch_last  = (ch == CH_W'(CHANNELS - 1));
  assign last_cap = cap_vld && ch_last && (idx == IDX_W'(FRAME_LEN - 1));
  assign wr_addr  = (AW'(ch) << IDX_W) | AW'(idx);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (last_cap)      state_nxt = READY;
      READY:   if (cpu_frame_ack) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // rdreq is gated by reset so no word is requested while reset is held
  always_comb begin
    fifo.fifo_rdreq = (state == FILL) && !reset_reset && !fifo.fifo_rdempty &&
                      (issued < CNT_W'(DEPTH));
    frame_ready     = (state == READY);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cap_vld <= 1'b0;
      ch      <= '0;
      idx     <= '0;
      issued  <= '0;
    end else begin
      cap_vld <= fifo.fifo_rdreq;
      if ((state == READY) && cpu_frame_ack) begin
        ch     <= '0;
        idx    <= '0;
        issued <= '0;
      end else begin
        if (fifo.fifo_rdreq) begin
          issued <= issued + 1'b1;
        end
        if (cap_vld) begin
          if (ch_last) begin
            ch  <= '0;
            idx <= idx + 1'b1;
          end else begin
            ch  <= ch + 1'b1;
          end
        end
      end
    end
  end

  ffb_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk_clk),
    .wr_en   (cap_vld),
    .wr_addr (wr_addr),
    .wr_data (fifo.fifo_q),
    .rd_addr (cpu_rd_addr),
    .rd_data (ram_q)
  );

  // Channel fields beyond CHANNELS read as zero; the flag tracks the RAM latency.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= ((cpu_rd_addr >> IDX_W) < AW'(CHANNELS));
    end
  end

  assign cpu_rd_data = rd_ok ? ram_q : '0;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      data_back     <= '0;
      data_back_stb <= 1'b0;
    end else begin
      data_back_stb <= cpu_back_wr;
      if (cpu_back_wr) begin
        data_back <= cpu_back_data;
      end
    end
  end

`ifdef FIFO_FRAME_BRIDGE_OVERRUN_CNT_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      overrun_cnt <= '0;
    end else if ((state == READY) && fifo.fifo_rdfull && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end
`else
  logic unused_rdfull;
  assign unused_rdfull = fifo.fifo_rdfull;
  assign overrun_cnt   = '0;
`endif

endmodule

// File: tb/tb_fifo_frame_bridge.sv
// Scoreboard bench for fifo_frame_bridge with a behavioural non-show-ahead FIFO.
module tb_fifo_frame_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        frame_ready;
  logic        ack = 1'b0;
  logic [31:0] back_data = '0;
  logic        back_wr = 1'b0;
  logic [31:0] data_back;
  logic        data_back_stb;
  logic [15:0] overrun_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] back_q [$];

  logic [31:0] feed_mem [256];
  int unsigned feed_wr = 0;
  int unsigned feed_rd = 0;
  int unsigned rdreq_cnt = 0;
  int unsigned guard_viol = 0;

  fifo_frame_bridge_if #(.DATA_W(32)) fifo_bus ();

  fifo_frame_bridge #(
    .DATA_W    (32),
    .CHANNELS  (2),
    .FRAME_LEN (16)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .fifo          (fifo_bus),
    .frame_ready   (frame_ready),
    .cpu_rd_addr   (rd_addr),
    .cpu_rd_data   (rd_data),
    .cpu_frame_ack (ack),
    .cpu_back_data (back_data),
    .cpu_back_wr   (back_wr),
    .data_back     (data_back),
    .data_back_stb (data_back_stb),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears one cycle after the request
  assign fifo_bus.fifo_rdempty = (feed_rd == feed_wr);

  always @(posedge clk) begin
    if (fifo_bus.fifo_rdreq) begin
      fifo_bus.fifo_q <= feed_mem[feed_rd];
      feed_rd         <= feed_rd + 1;
      rdreq_cnt       <= rdreq_cnt + 1;
      if (fifo_bus.fifo_rdempty || frame_ready) guard_viol <= guard_viol + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] v);
    feed_mem[feed_wr] = v;
    feed_wr++;
    exp_q.push_back(v);
  endtask

  task automatic wait_frame(input string tag);
    int unsigned n = 0;
    while (!frame_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_ready) check_eq(tag, 32'(frame_ready), 32'd1);
  endtask

  task automatic read_addr(input logic [4:0] a, output logic [31:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic readout(input string tag);
    logic [4:0]  a;
    logic [31:0] d;
    for (int k = 0; k < 32; k++) begin
      a = 5'(((k % 2) << 4) | (k / 2));
      read_addr(a, d);
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else                   check_eq(tag, d, exp_q.pop_front());
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_rdreq"},  32'(fifo_bus.fifo_rdreq), 32'd0);
    check_eq({tag, "_ready"},  32'(frame_ready), 32'd0);
    check_eq({tag, "_rddata"}, rd_data, 32'd0);
    check_eq({tag, "_back"},   data_back, 32'd0);
    check_eq({tag, "_stb"},    32'(data_back_stb), 32'd0);
    check_eq({tag, "_ovr"},    32'(overrun_cnt), 32'd0);
  endtask

  initial begin
    int unsigned base;
    int unsigned n;
    logic [31:0] d;

    fifo_bus.fifo_rdfull = 1'b0;
    for (int i = 0; i < 32; i++) push_word(32'(i));
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    // frame 1: FIFO pre-loaded with 0..31
    base = rdreq_cnt;
    rst  = 1'b0;
    wait_frame("frame1_timeout");
    check_eq("frame1_rdreqs", 32'(rdreq_cnt - base), 32'd32);
    read_addr(5'd3, d);
    check_eq("addr_0_3", d, 32'd6);
    read_addr(5'd19, d);
    check_eq("addr_1_3", d, 32'd7);

    // READY holds the buffer and issues no request while the FIFO has data
    for (int i = 0; i < 32; i++) push_word(32'(100 + i));
    repeat (3) @(negedge clk);
    check_eq("rdreq_in_ready", 32'(fifo_bus.fifo_rdreq), 32'd0);
    readout("frame1_data");

    base = rdreq_cnt;
    pulse_ack();
    check_eq("ack_ready_low", 32'(frame_ready), 32'd0);
    check_eq("ack_rdreq_high", 32'(fifo_bus.fifo_rdreq), 32'd1);
    pulse_ack();
    wait_frame("frame2_timeout");
    check_eq("frame2_rdreqs", 32'(rdreq_cnt - base), 32'd32);
    readout("frame2_data");

    // FIFO runs dry after 10 words, refilled well after it emptied
    pulse_ack();
    base = rdreq_cnt;
    for (int i = 0; i < 10; i++) push_word(32'(200 + i));
    repeat (32) @(negedge clk);
    check_eq("dry_rdreqs", 32'(rdreq_cnt - base), 32'd10);
    check_eq("dry_rdreq_low", 32'(fifo_bus.fifo_rdreq), 32'd0);
    for (int i = 10; i < 32; i++) push_word(32'(200 + i));
    wait_frame("frame3_timeout");
    check_eq("frame3_rdreqs", 32'(rdreq_cnt - base), 32'd32);
    readout("frame3_data");
    check_eq("rdreq_guard", 32'(guard_viol), 32'd0);

    // back-to-back result writes
    back_wr   = 1'b1;
    back_data = 32'hDEADBEEF;
    back_q.push_back(back_data);
    @(negedge clk);
    check_eq("back_stb1", 32'(data_back_stb), 32'd1);
    check_eq("back_data1", data_back, back_q.pop_front());
    back_data = 32'h12345678;
    back_q.push_back(back_data);
    @(negedge clk);
    back_wr = 1'b0;
    check_eq("back_stb2", 32'(data_back_stb), 32'd1);
    check_eq("back_data2", data_back, back_q.pop_front());
    @(negedge clk);
    check_eq("back_stb_end", 32'(data_back_stb), 32'd0);
    check_eq("back_hold", data_back, 32'h12345678);

    // reset after 17 captures discards the partial frame
    pulse_ack();
    base = rdreq_cnt;
    for (int i = 0; i < 17; i++) push_word(32'(300 + i));
    n = 0;
    while ((rdreq_cnt - base) < 17 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_rdreqs", 32'(rdreq_cnt - base), 32'd17);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    exp_q.delete();
    rst  = 1'b0;
    base = rdreq_cnt;
    for (int i = 0; i < 32; i++) push_word(32'(400 + i));
    wait_frame("frame4_timeout");
    check_eq("frame4_rdreqs", 32'(rdreq_cnt - base), 32'd32);
    readout("frame4_data");

    fifo_bus.fifo_rdfull = 1'b1;
`ifdef FIFO_FRAME_BRIDGE_OVERRUN_CNT_EN
    repeat (70000) @(negedge clk);
    check_eq("overrun_sat", 32'(overrun_cnt), 32'h0000FFFF);
`else
    repeat (200) @(negedge clk);
    check_eq("overrun_off", 32'(overrun_cnt), 32'd0);
`endif
    fifo_bus.fifo_rdfull = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_frame_bridge.md
FIFO_FRAME_BRIDGE -- requirements
Module: fifo_frame_bridge

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of FIFO samples and CPU data words.
REQ-002 The block SHALL have parameter CHANNELS, default 2: number of interleaved channels, range 1..8.
REQ-003 The block SHALL have parameter FRAME_LEN, default 16: samples per channel per frame, power of two, range 2..256.
REQ-004 The block SHALL have port clk_clk, input, 1 bit: the single clock; all logic is synchronous to its rising edge.
REQ-005 The block SHALL have port reset_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port fifo_q, input, DATA_W bits: FIFO read data, valid one cycle after fifo_rdreq (non-show-ahead).
REQ-007 The block SHALL have port fifo_rdempty, input, 1 bit: FIFO empty flag.
REQ-008 The block SHALL have port fifo_rdfull, input, 1 bit: FIFO full flag.
REQ-009 The block SHALL have port fifo_rdreq, output, 1 bit: FIFO read request.
REQ-010 The block SHALL have port frame_ready, output, 1 bit: a complete frame is held for the CPU.
REQ-011 The block SHALL have port cpu_rd_addr, input, AW bits, where AW = clog2(CHANNELS) + clog2(FRAME_LEN) and the value is {channel, sample index}.
REQ-012 The block SHALL have port cpu_rd_data, output, DATA_W bits: buffer read data, registered.
REQ-013 The block SHALL have port cpu_frame_ack, input, 1 bit: single-cycle pulse releasing the held frame.
REQ-014 The block SHALL have port cpu_back_data, input, DATA_W bits: processed result from the CPU.
REQ-015 The block SHALL have port cpu_back_wr, input, 1 bit: write strobe for cpu_back_data.
REQ-016 The block SHALL have port data_back, output, DATA_W bits: held result for downstream logic.
REQ-017 The block SHALL have port data_back_stb, output, 1 bit: one-cycle pulse signalling that data_back was updated.
REQ-018 The block SHALL have port overrun_cnt, output, 16 bits: overrun statistic (see Configuration).

Function
REQ-019 The block SHALL implement two states: FILL and READY.
REQ-020 In FILL, fifo_rdreq SHALL be asserted combinationally = !fifo_rdempty && issued < CHANNELS*FRAME_LEN; it SHALL never be asserted in READY or while fifo_rdempty is high.
REQ-021 Each word SHALL be captured the cycle after its rdreq and written to buffer address {ch, idx}; ch increments per word and wraps at CHANNELS-1 -> 0, and idx increments on each ch wrap.
REQ-022 The block SHALL move FILL -> READY in the cycle the last word (ch = CHANNELS-1, idx = FRAME_LEN-1) is captured; frame_ready SHALL rise the following cycle.
REQ-023 READY -> FILL SHALL occur on cpu_frame_ack, clearing frame_ready, ch, idx and issued the next cycle; cpu_frame_ack in FILL SHALL be ignored.
REQ-024 cpu_rd_data SHALL equal buffer[cpu_rd_addr] one cycle after the address is presented, in either state; an address with channel field >= CHANNELS SHALL return 0.
REQ-025 Buffer contents SHALL be stable in READY; a CPU read in FILL returns partially overwritten data and is not an error.
REQ-026 cpu_back_wr SHALL latch cpu_back_data into data_back and pulse data_back_stb high for exactly one cycle; back-to-back strobes SHALL update every cycle with data_back_stb held high.
REQ-027 The data_back path SHALL be independent of the FILL/READY state.

Reset
REQ-028 Reset SHALL force: state FILL, fifo_rdreq 0, frame_ready 0, cpu_rd_data 0, data_back 0, data_back_stb 0, overrun_cnt 0, and ch, idx and issued cleared.
REQ-029 Reset mid-frame SHALL discard the partial frame and any in-flight capture; a FIFO word already requested is lost, and buffer RAM is not cleared.

Configuration
REQ-030 With FIFO_FRAME_BRIDGE_OVERRUN_CNT_EN defined, overrun_cnt SHALL increment, saturating at 0xFFFF, on each cycle in which state is READY and fifo_rdfull = 1.
REQ-031 Without FIFO_FRAME_BRIDGE_OVERRUN_CNT_EN, overrun_cnt SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-032 A shared package fifo_frame_bridge_pkg SHALL hold the state enum (FILL, READY) and the overrun counter width constant (16).
REQ-033 The buffer SHALL be one sub-module, ffb_frame_ram: simple dual-port, one write port, one registered read port, depth CHANNELS*FRAME_LEN.

Verification
REQ-034 Defaults, FIFO pre-loaded with 32 words 0..31 -> 32 rdreq pulses, then frame_ready; address {0,3} reads 6 and address {1,3} reads 7.
REQ-035 FIFO empties after 10 words and refills 20 cycles later -> rdreq stays low while empty, no duplicate or lost words, and the frame completes correctly.
REQ-036 In READY, FIFO non-empty, ack pulsed -> frame_ready low and rdreq high the next cycle; a second ack during FILL -> no effect.
REQ-037 Reset asserted after 17 captures -> all outputs 0; the next frame begins at address {0,0}.
REQ-038 cpu_back_wr pulsed with 0xDEADBEEF then 0x12345678 on consecutive cycles -> data_back follows, data_back_stb high for 2 cycles.
REQ-039 Macro on, READY held with fifo_rdfull high for 70000 cycles -> overrun_cnt = 0xFFFF; macro off -> overrun_cnt = 0.
